// File: rtl/bg_tile_fetcher_if.sv
// VRAM read bus and packed-tile handshake between the tile fetcher
// (master) and the memory / background shifter side (slave).
interface bg_tile_fetcher_if #(
    parameter int ADDR_W = 16
);
    logic [ADDR_W-1:0] vram_addr;
    logic              vram_rd_req;
    logic              vram_rd_valid;
    logic [7:0]        vram_rd_data;
    logic              tile_valid;
    logic              tile_ready;
    logic [7:0]        tile_pat_lo;
    logic [7:0]        tile_pat_hi;
    logic [1:0]        tile_pal;

    modport master (
        output vram_addr, vram_rd_req,
        output tile_valid, tile_pat_lo,
        output tile_pat_hi, tile_pal,
        input  vram_rd_valid, vram_rd_data,
        input  tile_ready
    );

    modport slave (
        input  vram_addr, vram_rd_req,
        input  tile_valid, tile_pat_lo,
        input  tile_pat_hi, tile_pal,
        output vram_rd_valid, vram_rd_data,
        output tile_ready
    );
endinterface

// File: rtl/bg_tile_fetcher.sv
// Background tile fetch sequencer: NT, AT, pattern lo/hi reads, then hands
// off one packed tile. Optional macro BG_FETCH_COARSE_X_INC_EN.
module bg_tile_fetcher #(
    parameter int              ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] PT_BASE_0 = 16'h0000,
    parameter logic [ADDR_W-1:0] PT_BASE_1 = 16'h1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_nt_addr,
    input  logic [2:0]        i_fine_y,
    input  logic              i_bg_pt_sel,
    output logic              o_busy,
    output logic [ADDR_W-1:0] o_nt_addr,
    input  logic [ADDR_W-1:0] i_attr_byte_addr,
    input  logic [1:0]        i_attr_bit_offset,
    bg_tile_fetcher_if.master bus
);

    typedef enum logic [2:0] {
        IDLE, F_NT, F_AT, F_PLO, F_PHI, HOLD
    } state_t;

    state_t            r_state;
    logic              r_busy;
    logic [ADDR_W-1:0] r_nt_addr;
    logic [2:0]        r_fine_y;
    logic              r_pt_sel;
    logic [7:0]        r_tile_idx;
    logic [7:0]        r_at_byte;
    logic [1:0]        r_attr_off;
    logic [7:0]        r_pat_lo;
    logic [7:0]        r_pat_hi;
    logic              r_armed;
    logic [ADDR_W-1:0] r_vram_addr;
    logic              r_rd_req;
    logic              r_tile_valid;

    logic [ADDR_W-1:0] w_nt_src;
    logic [ADDR_W-1:0] w_pt_base;
    logic [ADDR_W-1:0] w_pat_addr;
    logic              w_acc;
    logic              w_hs;

`ifdef BG_FETCH_COARSE_X_INC_EN
    logic [ADDR_W-1:0] r_ptr;
    logic              r_ptr_vld;
    logic [ADDR_W-1:0] w_ptr_inc;

    // Coarse X wrap flips the horizontal nametable select bit.
    assign w_ptr_inc = (r_ptr[4:0] == 5'd31) ?
        {r_ptr[ADDR_W-1:11], ~r_ptr[10], r_ptr[9:5], 5'd0} :
        {r_ptr[ADDR_W-1:5], r_ptr[4:0] + 5'd1};
    assign w_nt_src = r_ptr_vld ? r_ptr : i_nt_addr;
`else
    assign w_nt_src = i_nt_addr;
`endif

    assign w_pt_base  = r_pt_sel ? PT_BASE_1 : PT_BASE_0;
    assign w_pat_addr = w_pt_base
                      + ADDR_W'({r_tile_idx, 4'h0})
                      + ADDR_W'(r_fine_y);
    // Valid in the first cycle of a fetch state is never trusted.
    assign w_acc = bus.vram_rd_valid && r_armed;
    assign w_hs  = r_tile_valid && bus.tile_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_busy       <= 1'b0;
            r_nt_addr    <= '0;
            r_fine_y     <= '0;
            r_pt_sel     <= 1'b0;
            r_tile_idx   <= '0;
            r_at_byte    <= '0;
            r_attr_off   <= '0;
            r_pat_lo     <= '0;
            r_pat_hi     <= '0;
            r_armed      <= 1'b0;
            r_vram_addr  <= '0;
            r_rd_req     <= 1'b0;
            r_tile_valid <= 1'b0;
`ifdef BG_FETCH_COARSE_X_INC_EN
            r_ptr        <= '0;
            r_ptr_vld    <= 1'b0;
`endif
        end else begin
            r_armed <= 1'b1;
            unique case (r_state)
                IDLE: begin
                    r_armed <= 1'b0;
                    if (i_start) begin
                        r_nt_addr   <= w_nt_src;
                        r_fine_y    <= i_fine_y;
                        r_pt_sel    <= i_bg_pt_sel;
                        r_vram_addr <= w_nt_src;
                        r_rd_req    <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= F_NT;
`ifdef BG_FETCH_COARSE_X_INC_EN
                        r_ptr       <= w_nt_src;
                        r_ptr_vld   <= 1'b1;
`endif
                    end
                end
                F_NT: if (w_acc) begin
                    r_tile_idx  <= bus.vram_rd_data;
                    r_vram_addr <= i_attr_byte_addr;
                    r_armed     <= 1'b0;
                    r_state     <= F_AT;
                end
                F_AT: if (w_acc) begin
                    r_at_byte   <= bus.vram_rd_data;
                    r_attr_off  <= i_attr_bit_offset;
                    r_vram_addr <= w_pat_addr;
                    r_armed     <= 1'b0;
                    r_state     <= F_PLO;
                end
                F_PLO: if (w_acc) begin
                    r_pat_lo    <= bus.vram_rd_data;
                    r_vram_addr <= r_vram_addr + ADDR_W'(8);
                    r_armed     <= 1'b0;
                    r_state     <= F_PHI;
                end
                F_PHI: if (w_acc) begin
                    r_pat_hi     <= bus.vram_rd_data;
                    r_rd_req     <= 1'b0;
                    r_tile_valid <= 1'b1;
                    r_armed      <= 1'b0;
                    r_state      <= HOLD;
                end
                HOLD: begin
                    r_armed <= 1'b0;
                    if (w_hs) begin
                        r_tile_valid <= 1'b0;
                        r_busy       <= 1'b0;
                        r_state      <= IDLE;
`ifdef BG_FETCH_COARSE_X_INC_EN
                        r_ptr        <= w_ptr_inc;
`endif
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_busy          = r_busy;
    assign o_nt_addr       = r_nt_addr;
    assign bus.vram_addr   = r_vram_addr;
    assign bus.vram_rd_req = r_rd_req;
    assign bus.tile_valid  = r_tile_valid;
    assign bus.tile_pat_lo = r_pat_lo;
    assign bus.tile_pat_hi = r_pat_hi;
    assign bus.tile_pal    = 2'(r_at_byte >> {r_attr_off, 1'b0});

endmodule

// File: tb/tb_bg_tile_fetcher.sv
// Randomized bench for bg_tile_fetcher: VRAM/translator models plus a
// per-tile reference of addresses, data, latency and handshake behaviour.
module tb_bg_tile_fetcher;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] nt_addr_in;
    logic [2:0]  fine_y;
    logic        pt_sel;
    logic        o_busy;
    logic [15:0] o_nt_addr;
    logic [15:0] attr_addr;
    logic [1:0]  attr_off;

    bg_tile_fetcher_if #(.ADDR_W(16)) bus ();

    bg_tile_fetcher dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_start           (start),
        .i_nt_addr         (nt_addr_in),
        .i_fine_y          (fine_y),
        .i_bg_pt_sel       (pt_sel),
        .o_busy            (o_busy),
        .o_nt_addr         (o_nt_addr),
        .i_attr_byte_addr  (attr_addr),
        .i_attr_bit_offset (attr_off),
        .bus               (bus)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [0:65535];
    logic [15:0] got_addr [$];
    int          waits [4];
    bit          spur [4];
    bit          spur_idle;
    int          n_chk;
    int          n_fail;
    logic [15:0] ptr;
    bit          ptr_vld;

    function automatic logic [15:0] tr_addr(logic [15:0] n);
        return 16'h23C0 | (n & 16'h0C00)
             | ((n >> 4) & 16'h0038) | ((n >> 2) & 16'h0007);
    endfunction

    function automatic logic [1:0] tr_off(logic [15:0] n);
        return {n[6], n[1]};
    endfunction

    function automatic logic [15:0] cx_inc(logic [15:0] n);
        if ((n & 16'h001F) == 16'h001F)
            return (n & 16'hFFE0) ^ 16'h0400;
        return n + 16'd1;
    endfunction

    assign attr_addr = tr_addr(o_nt_addr);
    assign attr_off  = tr_off(o_nt_addr);

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // VRAM responder: valid after waits[i] cycles of fetch i.
    initial begin
        int          cyc;
        int          fi;
        int          w;
        bit          prev_acc;
        bit          active;
        logic [15:0] ra;
        cyc = 0; fi = 0; prev_acc = 0; active = 0; ra = '0;
        bus.vram_rd_valid = 1'b0;
        bus.vram_rd_data  = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst_n || !bus.vram_rd_req) begin
                cyc = 0; fi = 0; prev_acc = 0; active = 0;
                bus.vram_rd_valid = spur_idle && ($urandom_range(0, 1) == 1);
                bus.vram_rd_data  = 8'($urandom);
            end else begin
                if (active) begin
                    if (prev_acc) begin fi++; cyc = 0; end
                    else cyc++;
                end else begin
                    cyc = 0; fi = 0;
                end
                active = 1;
                if (cyc == 0) begin
                    ra = bus.vram_addr;
                    got_addr.push_back(bus.vram_addr);
                end else begin
                    chk("addr_stable", bus.vram_addr, ra);
                end
                w = (fi < 4) ? waits[fi] : 1;
                if (cyc == 0 && fi < 4 && spur[fi]) begin
                    bus.vram_rd_valid = 1'b1;
                    bus.vram_rd_data  = ~mem[bus.vram_addr];
                    prev_acc = 0;
                end else if (cyc >= w) begin
                    bus.vram_rd_valid = 1'b1;
                    bus.vram_rd_data  = mem[bus.vram_addr];
                    prev_acc = 1;
                end else begin
                    bus.vram_rd_valid = 1'b0;
                    bus.vram_rd_data  = 8'($urandom);
                    prev_acc = 0;
                end
            end
        end
    end

    task automatic set_waits(input int a, input int b, input int c,
                             input int d);
        waits[0] = a; waits[1] = b; waits[2] = c; waits[3] = d;
        for (int i = 0; i < 4; i++) spur[i] = 0;
    endtask

    task automatic fetch(input logic [15:0] nt_in, input logic [2:0] fy,
                         input logic sel, input int hold_n,
                         input bit hs_start);
        logic [15:0] nt, at, plo, phi;
        logic [7:0]  idx, ab, lo, hi;
        logic [1:0]  off, pal;
        int          lat, k;
        nt = nt_in;
`ifdef BG_FETCH_COARSE_X_INC_EN
        if (ptr_vld) nt = ptr;
        ptr_vld = 1;
`endif
        at  = tr_addr(nt);
        off = tr_off(nt);
        idx = mem[nt];
        ab  = mem[at];
        plo = (sel ? 16'h1000 : 16'h0000) + {4'h0, idx, 4'h0} + {13'd0, fy};
        phi = plo + 16'd8;
        lo  = mem[plo];
        hi  = mem[phi];
        pal = 2'((ab >> (2 * off)) & 8'h03);
        lat = 1;
        for (int i = 0; i < 4; i++) lat += waits[i] + 1;
        got_addr.delete();
        bus.tile_ready = (hold_n == 0);
        @(negedge clk);
        start = 1'b1; nt_addr_in = nt_in; fine_y = fy; pt_sel = sel;
        @(negedge clk);
        k = 1;
        while (!bus.tile_valid && k < 300) begin
            chk("busy_fetch", o_busy, 1);
            chk("nt_out", o_nt_addr, nt);
            start      = ($urandom_range(0, 3) == 0);
            nt_addr_in = 16'($urandom);
            fine_y     = 3'($urandom);
            pt_sel     = 1'($urandom);
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        chk("latency", k, lat);
        chk("n_addr", got_addr.size(), 4);
        if (got_addr.size() == 4) begin
            chk("addr_nt", got_addr[0], nt);
            chk("addr_at", got_addr[1], at);
            chk("addr_plo", got_addr[2], plo);
            chk("addr_phi", got_addr[3], phi);
        end
        for (int h = 0; h <= hold_n; h++) begin
            if (h > 0) @(negedge clk);
            chk("hold_valid", bus.tile_valid, 1);
            chk("hold_req", bus.vram_rd_req, 0);
            chk("hold_busy", o_busy, 1);
            chk("pat_lo", bus.tile_pat_lo, lo);
            chk("pat_hi", bus.tile_pat_hi, hi);
            chk("pal", bus.tile_pal, pal);
            start      = (h < hold_n) && ($urandom_range(0, 1) == 1);
            nt_addr_in = 16'($urandom);
        end
        bus.tile_ready = 1'b1;
        start = hs_start;
        @(negedge clk);
        bus.tile_ready = 1'b0;
        start = 1'b0;
        chk("post_valid", bus.tile_valid, 0);
        chk("post_busy", o_busy, 0);
        chk("post_nt_out", o_nt_addr, nt);
`ifdef BG_FETCH_COARSE_X_INC_EN
        ptr = cx_inc(nt);
`endif
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ptr_vld = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        ptr = '0; ptr_vld = 0;
        start = 0; nt_addr_in = '0; fine_y = '0; pt_sel = 0;
        bus.tile_ready = 1'b0;
        spur_idle = 0;
        set_waits(1, 1, 1, 1);
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", o_busy, 0);
        chk("rst_req", bus.vram_rd_req, 0);
        chk("rst_valid", bus.tile_valid, 0);
        chk("rst_addr", bus.vram_addr, 0);
        chk("rst_nt_out", o_nt_addr, 0);
        chk("rst_pat", {bus.tile_pat_lo, bus.tile_pat_hi}, 0);
        chk("rst_pal", bus.tile_pal, 0);
        rst_n = 1'b1;

        spur_idle = 1;
        repeat (4) begin
            @(negedge clk);
            chk("idle_busy", o_busy, 0);
            chk("idle_req", bus.vram_rd_req, 0);
        end

        mem[16'h2042] = 8'h5A;
        mem[16'h23C0] = 8'hC0;
        fetch(16'h2042, 3'd3, 1'b1, 0, 0);
        chk("dir_pal", bus.tile_pal, 2'b11);

        fetch(16'h2000 + 16'($urandom_range(0, 16'h0FFF)), 3'($urandom),
              1'($urandom), 5, 1);

        set_waits(1, 1, 3, 3);
        spur[1] = 1;
        fetch(16'h2000 + 16'($urandom_range(0, 16'h0FFF)), 3'($urandom),
              1'($urandom), 1, 0);

        set_waits(1, 1, 1, 1);
        @(negedge clk);
        start = 1'b1; nt_addr_in = 16'h2123; fine_y = 3'd5; pt_sel = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("plo_req", bus.vram_rd_req, 1);
        rst_n = 1'b0;
        ptr_vld = 0;
        #1;
        chk("arst_req", bus.vram_rd_req, 0);
        chk("arst_busy", o_busy, 0);
        chk("arst_valid", bus.tile_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        fetch(16'h2123, 3'd5, 1'b0, 0, 0);

        for (int t = 0; t < 20; t++) begin
            set_waits($urandom_range(1, 4), $urandom_range(1, 4),
                      $urandom_range(1, 4), $urandom_range(1, 4));
            for (int i = 0; i < 4; i++) spur[i] = ($urandom_range(0, 2) == 0);
            fetch(16'($urandom), 3'($urandom), 1'($urandom),
                  $urandom_range(0, 3), 1'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

`ifdef BG_FETCH_COARSE_X_INC_EN
        set_waits(1, 1, 1, 1);
        do_reset();
        fetch(16'h201F, 3'd0, 1'b0, 0, 0);
        fetch(16'h3333, 3'd0, 1'b0, 0, 0);
        if (got_addr.size() > 0) chk("cx_wrap", got_addr[0], 16'h2400);
        else chk("cx_wrap_n", 0, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bg_tile_fetcher.md
Name: bg_tile_fetcher

Overview:
- Background tile fetch sequencer for the PPU. Per requested tile, reads four bytes from VRAM in order: nametable, attribute, pattern low plane, pattern high plane.
- Drives the nametable-to-attribute translator with the current nametable address and consumes its attribute byte address and quadrant offset.
- Presents one packed tile (two pattern bytes plus 2-bit palette select) to the background shifter stage through a valid/ready handshake.

Parameters:
- ADDR_W, 16, VRAM address width.
- PT_BASE_0, 16'h0000, pattern table base when bg_pt_sel=0.
- PT_BASE_1, 16'h1000, pattern table base when bg_pt_sel=1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to fetch one tile. Accepted only when busy=0.
- nt_addr_in  in  ADDR_W  nametable byte address; sampled on an accepted start.
- fine_y  in  3  pixel row within tile; sampled on an accepted start.
- bg_pt_sel  in  1  pattern table select; sampled on an accepted start.
- busy  out  1  high from accepted start until the tile is handed off.
- nt_addr_out  out  ADDR_W  latched nametable address, fed to the translator.
- attr_byte_addr  in  ADDR_W  from the translator.
- attr_bit_offset  in  2  from the translator.
- vram_addr  out  ADDR_W  read address.
- vram_rd_req  out  1  read request.
- vram_rd_valid  in  1  read data valid.
- vram_rd_data  in  8  read data.
- tile_valid  out  1  packed tile available.
- tile_ready  in  1  downstream accepts the tile.
- tile_pat_lo  out  8  pattern low plane byte.
- tile_pat_hi  out  8  pattern high plane byte.
- tile_pal  out  2  palette select.

Behaviour:
- Reset values: all outputs 0, state IDLE.
- States: IDLE, F_NT, F_AT, F_PLO, F_PHI, HOLD.
- IDLE:
  - busy=0.
  - On start: latch nt_addr_in, fine_y and bg_pt_sel; go to F_NT.
- F_* states:
  - vram_rd_req=1 with vram_addr stable for the whole state.
  - vram_rd_valid is sampled only from the 2nd cycle of the state onward; valid in the 1st cycle is ignored.
  - On a sampled valid: capture vram_rd_data, then advance. vram_rd_req stays high across consecutive fetches; vram_addr changes on the state transition.
  - vram_rd_valid while in IDLE or HOLD is ignored.
- F_NT: vram_addr = latched nametable address; capture tile index.
- F_AT:
  - vram_addr = attr_byte_addr.
  - On valid: palette = (data >> (2*attr_bit_offset)) & 2'b11; latch attr_bit_offset.
- F_PLO: vram_addr = base + {tile_idx,4'b0} + fine_y, where base = PT_BASE_0 or PT_BASE_1 per the latched bg_pt_sel. Capture low plane.
- F_PHI: vram_addr = same + 8. Capture high plane; go to HOLD with vram_rd_req=0.
- HOLD:
  - tile_valid=1; tile outputs held stable until tile_ready.
  - When tile_valid && tile_ready in the same cycle: tile_valid=0 next cycle, return to IDLE.
- Latency: start in cycle 0 with single-wait memory (valid in the 2nd cycle of every state) gives tile_valid in cycle 9.
- busy is high for the whole of F_* and HOLD.
- nt_addr_out is registered and constant from the cycle after start until the next accepted start.
- Boundary conditions:
  - start while busy=1: ignored, latched inputs unchanged.
  - start in the same cycle as a HOLD handshake: ignored; the new start is accepted only in IDLE.
  - rst_n low in any state: immediate return to IDLE; vram_rd_req and tile_valid drop asynchronously; any partial tile is discarded.
  - Address arithmetic wraps modulo 2^ADDR_W.

Optional Feature:
- Macro: BG_FETCH_COARSE_X_INC_EN.
- With the macro defined:
  - start sources the nametable address from an internal pointer. The pointer is loaded from nt_addr_in on start only when busy=0 and the pointer is unloaded after reset.
  - On each HOLD handshake, coarse X (bits 4:0) increments. On 31 it wraps to 0 and bit 10 toggles (horizontal nametable switch). Other bits are untouched.
- Without the macro: nt_addr_in is sampled on every accepted start and no pointer exists.

Test Plan:
- nt_addr_in=16'h2042, translator returns 16'h23C0 / offset 3; VRAM nt=8'h5A, at=8'hC0, bg_pt_sel=1, fine_y=3 -> vram_addr sequence 2042, 23C0, 15A3, 15AB; tile_pal=2'b11.
- Single-wait memory, tile_ready tied high -> tile_valid asserted in cycle 9 after start and held 1 cycle; busy high cycles 1-9.
- tile_ready held low 5 cycles in HOLD -> tile_valid and tile outputs held stable; start pulses during HOLD ignored; no new VRAM request.
- vram_rd_valid asserted in the 1st cycle of F_AT and in IDLE -> ignored; 3-cycle wait on the pattern reads -> correct capture, vram_addr stable throughout.
- rst_n pulsed low during F_PLO -> vram_rd_req=0 and busy=0 immediately; following start fetches a clean tile.
- BG_FETCH_COARSE_X_INC_EN defined: load 16'h201F, fetch two tiles -> second fetch nametable address is 16'h2400.
